// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and small-sigma helpers used by the message scheduler.
package sha256_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ROUNDS = 64;
    localparam int unsigned WIN    = 16;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned PTR_W  = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } w_sched_state_t;

    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational SHA-256 schedule step: W[t] from W[t-16], W[t-15], W[t-7], W[t-2].
module sha256_w_expand
    import sha256_pkg::*;
(
    input  logic [31:0] wm16,
    input  logic [31:0] wm15,
    input  logic [31:0] wm7,
    input  logic [31:0] wm2,
    output logic [31:0] w_new
);

    assign w_new = wm16 + small_sigma0(wm15) + wm7 + small_sigma1(wm2);

endmodule

// File: rtl/sha256_w_scheduler.sv
// SHA-256 message-schedule sequencer: loads M[0..15] into a 16-word ring, streams W[0..63].
// Optional stall counter output enabled by defining W_SCHED_STALL_CNT_EN.
module sha256_w_scheduler
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_word,
    output logic        wt_valid,
    input  logic        wt_ready,
    output logic [31:0] wt,
    output logic [5:0]  wt_idx,
    output logic        busy,
    output logic        done
`ifdef W_SCHED_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    w_sched_state_t   state;
    w_sched_state_t   state_nxt;
    word_t            ring [WIN];
    logic [PTR_W-1:0] load_cnt;
    logic [IDX_W-1:0] t;
    logic [PTR_W-1:0] p0;
    logic [PTR_W-1:0] p1;
    logic [PTR_W-1:0] p9;
    logic [PTR_W-1:0] p14;
    word_t            w_new;
    word_t            wt_sel;

    // Ring slots holding W[t-16], W[t-15], W[t-7], W[t-2]
    assign p0  = t[PTR_W-1:0];
    assign p1  = p0 + PTR_W'(1);
    assign p9  = p0 + PTR_W'(9);
    assign p14 = p0 + PTR_W'(14);

    sha256_w_expand u_expand (
        .wm16  (ring[p0]),
        .wm15  (ring[p1]),
        .wm7   (ring[p9]),
        .wm2   (ring[p14]),
        .w_new (w_new)
    );

    assign wt_sel = (t[IDX_W-1:PTR_W] == '0) ? ring[p0] : w_new;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        msg_ready = 1'b0;
        wt_valid  = 1'b0;
        wt_idx    = '0;
        wt        = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid && load_cnt == PTR_W'(WIN - 1)) state_nxt = RUN;
            end
            RUN: begin
                wt_valid = 1'b1;
                wt_idx   = t;
                wt       = wt_sel;
                if (wt_ready && t == IDX_W'(ROUNDS - 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ring fill during LOAD; in RUN each accepted word replaces the W[t-16] it no longer needs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(WIN); i++) ring[i] <= '0;
            load_cnt <= '0;
            t        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load_cnt <= '0;
                        t        <= '0;
                    end
                end
                LOAD: begin
                    if (msg_valid && msg_ready) begin
                        ring[load_cnt] <= msg_word;
                        load_cnt       <= load_cnt + PTR_W'(1);
                        t              <= '0;
                    end
                end
                RUN: begin
                    if (wt_valid && wt_ready) begin
                        ring[p0] <= wt_sel;
                        t        <= t + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef W_SCHED_STALL_CNT_EN
    // Saturating count of RUN cycles where the consumer holds off
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && !wt_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_w_scheduler.sv
// Self-checking bench for sha256_w_scheduler: reference schedule model plus directed scenarios.
module tb_sha256_w_scheduler;

    typedef logic [31:0] w32_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_word;
    logic        wt_valid;
    logic        wt_ready;
    logic [31:0] wt;
    logic [5:0]  wt_idx;
    logic        busy;
    logic        done;
`ifdef W_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    sha256_w_scheduler dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_word  (msg_word),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .wt        (wt),
        .wt_idx    (wt_idx),
        .busy      (busy),
        .done      (done)
`ifdef W_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    w32_t exp_w [64];
    w32_t got_w [64];
    int   ptr        = 0;
    bit   exp_active = 1'b0;
    bit   done_due   = 1'b0;
    bit   checking   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic w32_t rotr(input w32_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full 64-entry schedule computed straight from the recurrence
    task automatic build_model(input w32_t m [16]);
        w32_t s0, s1;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                exp_w[i] = m[i];
            end else begin
                s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
                s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
                exp_w[i] = exp_w[i-16] + s0 + exp_w[i-7] + s1;
            end
        end
        ptr        = 0;
        exp_active = 1'b1;
    endtask

    // Scoreboard: every cycle W stream and done pulse against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("done_pulse", 32'(done), 32'(done_due));
            done_due = 1'b0;
            if (exp_active) begin
                if (wt_valid) begin
                    chk("wt_idx", 32'(wt_idx), 32'(ptr));
                    chk("wt", wt, exp_w[ptr]);
                    got_w[ptr] = wt;
                    if (wt_ready) begin
                        ptr++;
                        if (ptr == 64) begin
                            exp_active = 1'b0;
                            done_due   = 1'b1;
                        end
                    end
                end
            end else begin
                chk("idle_wt_valid", 32'(wt_valid), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_msg_ready"}, 32'(msg_ready), 32'd0);
        chk({tag, "_wt_valid"}, 32'(wt_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_wt_idx"}, 32'(wt_idx), 32'd0);
        chk({tag, "_wt"}, wt, 32'd0);
    endtask

    task automatic start_block();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_block(input w32_t m [16], input bit gappy);
        int i   = 0;
        int cyc = 0;
        bit ph  = 1'b0;
        build_model(m);
        while (i < 16 && cyc < 200) begin
            msg_valid = gappy ? ph : 1'b1;
            ph        = ~ph;
            msg_word  = m[i];
            @(negedge clk);
            chk("msg_ready_in_load", 32'(msg_ready), 32'd1);
            if (msg_valid) i++;
            step();
            cyc++;
        end
        msg_valid = 1'b0;
        msg_word  = '0;
        chk("load_finished", 32'(i), 32'd16);
        @(negedge clk);
        chk("run_first_valid", 32'(wt_valid), 32'd1);
        chk("run_first_idx", 32'(wt_idx), 32'd0);
        chk("msg_ready_in_run", 32'(msg_ready), 32'd0);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < budget);
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_idx(input int idx);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(wt_valid && wt_idx == 6'(idx)) && c < 300);
        chk("reach_idx", 32'(wt_idx), 32'(idx));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w32_t blk [16];
        int   cyc;
        w32_t held;

        reset_n   = 1'b0;
        start     = 1'b0;
        msg_valid = 1'b0;
        msg_word  = '0;
        wt_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n  = 1'b1;
        checking = 1'b1;
        step();

        // "abc" padded block, consumer always ready
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        start_block();
        load_block(blk, 1'b0);
        chk("model_w16", exp_w[16], 32'h61626380);
        chk("model_w17", exp_w[17], 32'h000F0000);
        chk("model_w18", exp_w[18], 32'h7DA86405);
        wait_done(200, cyc);
        chk("abc_cycles", 32'(cyc), 32'd64);
        chk("abc_dut_w0", got_w[0], 32'h61626380);
        chk("abc_dut_w15", got_w[15], 32'h00000018);
        chk("abc_dut_w16", got_w[16], 32'h61626380);
        chk("abc_dut_w17", got_w[17], 32'h000F0000);
        chk("abc_dut_w18", got_w[18], 32'h7DA86405);

        // All-zero block launched the cycle after DONE
        step();
        for (int i = 0; i < 16; i++) blk[i] = '0;
        start_block();
        load_block(blk, 1'b0);
        wait_done(200, cyc);
        chk("zero_cycles", 32'(cyc), 32'd64);
        chk("zero_dut_w63", got_w[63], 32'd0);
        step();
        @(negedge clk);
        chk("idle_after_done_busy", 32'(busy), 32'd0);
        chk("idle_after_done_done", 32'(done), 32'd0);
        step();

        // Backpressure: five stalled cycles on W[20]
        for (int i = 0; i < 16; i++) blk[i] = (32'(i) * 32'h01234567) ^ 32'hDEADBEEF;
        start_block();
        load_block(blk, 1'b0);
        wait_idx(19);
        wt_ready = 1'b0;
        @(negedge clk);
        held = wt;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_idx", 32'(wt_idx), 32'd20);
            chk("stall_wt", wt, held);
            chk("stall_valid", 32'(wt_valid), 32'd1);
            step();
        end
        wt_ready = 1'b1;
        wait_done(200, cyc);
`ifdef W_SCHED_STALL_CNT_EN
        chk("stall_cnt_at_done", 32'(stall_cnt), 32'd5);
`endif
        chk("stall_model_w20", got_w[20], exp_w[20]);
        step();
        step();

        // Gappy load with a start pulse at t=30 that must be ignored
        for (int i = 0; i < 16; i++) blk[i] = 32'h0F1E2D3C + (32'(i) << 24) + 32'(i * 7);
        start_block();
        load_block(blk, 1'b1);
        wait_idx(29);
        start_block();
        @(negedge clk);
        chk("start_ignored_idx", 32'(wt_idx), 32'd31);
        chk("start_ignored_valid", 32'(wt_valid), 32'd1);
        chk("start_ignored_msg_ready", 32'(msg_ready), 32'd0);
        wait_done(200, cyc);

        // Back-to-back block started in the cycle right after DONE
        step();
        for (int i = 0; i < 16; i++) blk[i] = ~(32'h13579BDF * 32'(i + 1));
        start_block();
        load_block(blk, 1'b0);
        wait_done(200, cyc);
        chk("b2b_cycles", 32'(cyc), 32'd64);

        // Reset pulse while presenting W[40], then a fresh block
        step();
        for (int i = 0; i < 16; i++) blk[i] = 32'hA5A5A5A5 ^ (32'(i) << 4);
        start_block();
        load_block(blk, 1'b0);
        wait_idx(39);
        reset_n = 1'b0;
        step();
        exp_active = 1'b0;
        reset_n    = 1'b1;
        check_all_zero("midrun_reset");
        step();
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        start_block();
        load_block(blk, 1'b0);
        wait_done(200, cyc);
        chk("post_reset_cycles", 32'(cyc), 32'd64);
        chk("post_reset_w17", got_w[17], 32'h000F0000);
        step();
        step();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
